// File: rtl/soml_stbc_encoder.sv
// Alamouti 2x1 STBC transmit encoder: one byte -> two Gray-mapped 16-QAM symbols -> two output slots.
// Optional feature macro: SOML_ENC_NORM_EN (unit-energy level constants instead of +-1/+-3 * 2**FRAC).
module soml_stbc_encoder #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       bits_in,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic             out_slot,
  output logic [WIDTH-1:0] out_tx1I,
  output logic [WIDTH-1:0] out_tx1Q,
  output logic [WIDTH-1:0] out_tx2I,
  output logic [WIDTH-1:0] out_tx2Q,
  output logic             done
);

`ifdef SOML_ENC_NORM_EN
  localparam logic signed [WIDTH-1:0] LVL1 = WIDTH'(1295);
  localparam logic signed [WIDTH-1:0] LVL3 = WIDTH'(3886);
`else
  localparam logic signed [WIDTH-1:0] LVL1 = WIDTH'(1 << FRAC);
  localparam logic signed [WIDTH-1:0] LVL3 = WIDTH'(3 << FRAC);
`endif

  typedef enum logic [1:0] {IDLE, MAP, SLOT0, SLOT1} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              bits_q, bits_d;
  logic signed [WIDTH-1:0] i1_q, q1_q, i2_q, q2_q;
  logic signed [WIDTH-1:0] i1_d, q1_d, i2_d, q2_d;
  logic signed [WIDTH-1:0] tx1i_q, tx1q_q, tx2i_q, tx2q_q;
  logic signed [WIDTH-1:0] tx1i_d, tx1q_d, tx2i_d, tx2q_d;
  logic                    busy_q, busy_d, valid_q, valid_d;
  logic                    slot_q, slot_d, done_q, done_d;

  // Gray code: 00->-3, 01->-1, 11->+1, 10->+3
  function automatic logic signed [WIDTH-1:0] gray_lvl(input logic [1:0] f);
    case (f)
      2'b00:   return -LVL3;
      2'b01:   return -LVL1;
      2'b11:   return LVL1;
      default: return LVL3;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    i1_d    = i1_q;
    q1_d    = q1_q;
    i2_d    = i2_q;
    q2_d    = q2_q;
    tx1i_d  = tx1i_q;
    tx1q_d  = tx1q_q;
    tx2i_d  = tx2i_q;
    tx2q_d  = tx2q_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    slot_d  = slot_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bits_d  = bits_in;
          busy_d  = 1'b1;
          state_d = MAP;
        end
      end
      MAP: begin
        // Levels and slot0 outputs load together so slot0 is valid the cycle after MAP.
        i1_d    = gray_lvl(bits_q[7:6]);
        q1_d    = gray_lvl(bits_q[5:4]);
        i2_d    = gray_lvl(bits_q[3:2]);
        q2_d    = gray_lvl(bits_q[1:0]);
        tx1i_d  = i1_d;
        tx1q_d  = q1_d;
        tx2i_d  = i2_d;
        tx2q_d  = q2_d;
        valid_d = 1'b1;
        slot_d  = 1'b0;
        state_d = SLOT0;
      end
      SLOT0: begin
        if (out_ready) begin
          tx1i_d  = -i2_q;
          tx1q_d  = q2_q;
          tx2i_d  = i1_q;
          tx2q_d  = -q1_q;
          slot_d  = 1'b1;
          state_d = SLOT1;
        end
      end
      default: begin
        if (out_ready) begin
          valid_d = 1'b0;
          slot_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bits_q  <= '0;
      i1_q    <= '0;
      q1_q    <= '0;
      i2_q    <= '0;
      q2_q    <= '0;
      tx1i_q  <= '0;
      tx1q_q  <= '0;
      tx2i_q  <= '0;
      tx2q_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      slot_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      i1_q    <= i1_d;
      q1_q    <= q1_d;
      i2_q    <= i2_d;
      q2_q    <= q2_d;
      tx1i_q  <= tx1i_d;
      tx1q_q  <= tx1q_d;
      tx2i_q  <= tx2i_d;
      tx2q_q  <= tx2q_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      slot_q  <= slot_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_slot  = slot_q;
  assign out_tx1I  = tx1i_q;
  assign out_tx1Q  = tx1q_q;
  assign out_tx2I  = tx2i_q;
  assign out_tx2Q  = tx2q_q;
  assign done      = done_q;

endmodule

// File: tb/tb_soml_stbc_encoder.sv
// Directed bench for soml_stbc_encoder with an expected-slot scoreboard queue.
module tb_soml_stbc_encoder;

`ifdef SOML_ENC_NORM_EN
  localparam int L1 = 1295;
  localparam int L3 = 3886;
`else
  localparam int L1 = 4096;
  localparam int L3 = 12288;
`endif

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [7:0]  bits_in;
  logic        busy, out_valid, out_slot, done;
  logic [15:0] out_tx1I, out_tx1Q, out_tx2I, out_tx2Q;

  int vectors = 0;
  int errors  = 0;
  int n;

  typedef struct {
    logic        slot;
    logic [15:0] a, b, c, d;
  } exp_t;
  exp_t q[$];

  soml_stbc_encoder #(.WIDTH(16), .FRAC(12)) dut (
    .clk(clk), .rst(rst), .start(start), .bits_in(bits_in), .out_ready(out_ready),
    .busy(busy), .out_valid(out_valid), .out_slot(out_slot),
    .out_tx1I(out_tx1I), .out_tx1Q(out_tx1Q), .out_tx2I(out_tx2I), .out_tx2Q(out_tx2Q),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] lv(input logic [1:0] f);
    case (f)
      2'b00:   return 16'(-L3);
      2'b01:   return 16'(-L1);
      2'b11:   return 16'(L1);
      default: return 16'(L3);
    endcase
  endfunction

  task automatic push_block(input logic [7:0] b);
    logic [15:0] i1, q1, i2, q2;
    i1 = lv(b[7:6]);
    q1 = lv(b[5:4]);
    i2 = lv(b[3:2]);
    q2 = lv(b[1:0]);
    q.push_back('{slot: 1'b0, a: i1, b: q1, c: i2, d: q2});
    q.push_back('{slot: 1'b1, a: 16'(-i2), b: q2, c: i1, d: 16'(-q1)});
  endtask

  task automatic do_start(input logic [7:0] b);
    start   = 1'b1;
    bits_in = b;
    push_block(b);
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("valid_wait", 32'(out_valid), 32'd1);
  endtask

  task automatic check_slot(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'(q.size()), 32'd1);
    end else begin
      e = q[0];
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_slot"}, 32'(out_slot), 32'(e.slot));
      chk({tag, "_tx1I"}, 32'(out_tx1I), 32'(e.a));
      chk({tag, "_tx1Q"}, 32'(out_tx1Q), 32'(e.b));
      chk({tag, "_tx2I"}, 32'(out_tx2I), 32'(e.c));
      chk({tag, "_tx2Q"}, 32'(out_tx2Q), 32'(e.d));
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; bits_in = '0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("por");
    chk("por_tx", 32'({out_tx1I, out_tx1Q} | {out_tx2I, out_tx2Q}), 32'd0);

    // T2 basic map with out_ready high
    do_start(8'h2D);
    chk("t2_busy_map", 32'(busy), 32'd1);
    chk("t2_valid_map", 32'(out_valid), 32'd0);
    wait_valid(n);
    chk("t2_latency", 32'(n), 32'd1);
    check_slot("t2_s0");
    handshake();
    check_slot("t2_s1");
    handshake();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_busy_done", 32'(busy), 32'd0);
    chk("t2_valid_done", 32'(out_valid), 32'd0);
    tick();
    chk("t2_done_pulse", 32'(done), 32'd0);

    // T3 backpressure in SLOT0
    out_ready = 1'b0;
    do_start(8'hFF);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      check_slot("t3_hold");
      tick();
    end
    check_slot("t3_s0");
    handshake();
    check_slot("t3_s1");
    handshake();
    chk("t3_done", 32'(done), 32'd1);
    tick();

    // T4 start while busy is ignored
    out_ready = 1'b0;
    do_start(8'hA5);
    wait_valid(n);
    start = 1'b1; bits_in = 8'h00;
    tick();
    start = 1'b0;
    check_slot("t4_s0");
    chk("t4_busy", 32'(busy), 32'd1);
    handshake();
    check_slot("t4_s1");
    handshake();
    chk("t4_done", 32'(done), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("t4_after");
    end
    chk("t4_queue", 32'(q.size()), 32'd0);

    // T5 back-to-back start on the done cycle
    out_ready = 1'b1;
    do_start(8'h2D);
    wait_valid(n);
    check_slot("t5a_s0");
    handshake();
    check_slot("t5a_s1");
    handshake();
    chk("t5_done", 32'(done), 32'd1);
    do_start(8'h00);
    chk("t5_busy", 32'(busy), 32'd1);
    wait_valid(n);
    chk("t5_latency", 32'(n), 32'd1);
    check_slot("t5b_s0");
    handshake();
    check_slot("t5b_s1");
    handshake();
    chk("t5b_done", 32'(done), 32'd1);
    tick();

    // T1 reset mid-SLOT0 drops the block
    out_ready = 1'b0;
    do_start(8'h77);
    wait_valid(n);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    q.delete();
    check_idle("t1_rst");
    chk("t1_tx1", 32'({out_tx1I, out_tx1Q}), 32'd0);
    chk("t1_tx2", 32'({out_tx2I, out_tx2Q}), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("t1_after");
    end

    // rst has priority over start
    rst = 1'b1; start = 1'b1; bits_in = 8'h2D;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_busy", 32'(busy), 32'd0);
    tick();
    chk("rst_prio_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
